// File: rtl/fifo_bytepack_if.sv
// Handshake bundle for fifo_bytepack: variable-size byte beats in, fixed-width words out.
// The block under test connects through the slave modport; the producer/consumer side uses master.
interface fifo_bytepack_if #(
    parameter int unsigned IN_BYTES    = 8,
    parameter int unsigned OUT_BYTES   = 4,
    parameter int unsigned DEPTH_BYTES = 256
);
    logic                             valid_in;
    logic                             ready_in;
    logic [$clog2(IN_BYTES)-1:0]      size;
    logic [8*IN_BYTES-1:0]            data_in;
    logic                             flush;
    logic                             valid_out;
    logic                             ready_out;
    logic [8*OUT_BYTES-1:0]           data_out;
    logic [$clog2(OUT_BYTES):0]       bytes_out;
    logic [$clog2(DEPTH_BYTES):0]     level;

    modport master (
        output valid_in, size, data_in, flush, ready_out,
        input  ready_in, valid_out, data_out, bytes_out, level
    );

    modport slave (
        input  valid_in, size, data_in, flush, ready_out,
        output ready_in, valid_out, data_out, bytes_out, level
    );
endinterface

// File: rtl/fifo_bytepack.sv
// Byte-granular width-converting FIFO: packs 1..IN_BYTES-byte beats into OUT_BYTES words,
// with a flush that drains a trailing partial word. Show-ahead read side.
module fifo_bytepack #(
    parameter int unsigned IN_BYTES    = 8,
    parameter int unsigned OUT_BYTES   = 4,
    parameter int unsigned DEPTH_BYTES = 256
) (
    input  logic           clock,
    input  logic           reset,
    fifo_bytepack_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(IN_BYTES);
    localparam int unsigned BW = $clog2(OUT_BYTES) + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                 state;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic [LW-1:0]          level_next;
    logic [LW-1:0]          wbytes;
    logic [LW-1:0]          rbytes;
    logic [7:0]             mem [DEPTH_BYTES];

    logic                   in_ready;
    logic                   out_valid;
    logic                   wr_acc;
    logic                   rd_acc;
    logic [BW-1:0]          out_bytes;
    logic [8*OUT_BYTES-1:0] out_data;

    // Handshake flags derive from registered state and reset only.
    always_comb begin
        in_ready  = !reset && (state == IDLE) &&
                    (level <= LW'(DEPTH_BYTES - IN_BYTES));
        out_valid = !reset && ((level >= LW'(OUT_BYTES)) ||
                    ((state == DRAIN) && (level != '0)));
    end

    always_comb begin
        out_bytes = '0;
        if (out_valid) begin
            if (level >= LW'(OUT_BYTES)) begin
                out_bytes = BW'(OUT_BYTES);
            end else begin
                out_bytes = level[BW-1:0];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned j = 0; j < OUT_BYTES; j++) begin
            if (BW'(j) < out_bytes) begin
                out_data[8*j +: 8] = mem[rd_ptr + AW'(j)];
            end
        end
    end

    always_comb begin
        wr_acc     = bus.valid_in && in_ready;
        rd_acc     = out_valid && bus.ready_out;
        wbytes     = wr_acc ? (LW'(bus.size) + LW'(1)) : '0;
        rbytes     = rd_acc ? LW'(out_bytes) : '0;
        level_next = level + wbytes - rbytes;
    end

    // Storage is deliberately left unreset; stale bytes are unreachable once level is cleared.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < IN_BYTES; i++) begin
                if (SW'(i) <= bus.size) begin
                    mem[wr_ptr + AW'(i)] <= bus.data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            state  <= IDLE;
        end else begin
            wr_ptr <= wr_ptr + wbytes[AW-1:0];
            rd_ptr <= rd_ptr + rbytes[AW-1:0];
            level  <= level_next;
            case (state)
                // Entry and exit are evaluated together, so a flush whose
                // cycle already empties the store never leaves DRAIN stuck.
                IDLE: begin
                    if (bus.flush && (level != '0) && (level_next != '0)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (level_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_in  = in_ready;
    assign bus.valid_out = out_valid;
    assign bus.data_out  = out_data;
    assign bus.bytes_out = out_bytes;
    assign bus.level     = level;

    a_level_bound: assert property (@(posedge clock) disable iff (reset)
        level <= LW'(DEPTH_BYTES));
    a_ptr_consistent: assert property (@(posedge clock) disable iff (reset)
        (wr_ptr - rd_ptr) == level[AW-1:0]);
endmodule

// File: tb/tb_fifo_bytepack.sv
// Scoreboard bench for fifo_bytepack: the driver queues expected bytes on write accept,
// a monitor compares every cycle against a byte-queue reference model.
module tb_fifo_bytepack;
    localparam int IN_BYTES  = 8;
    localparam int OUT_BYTES = 4;
    localparam int DEPTH     = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fifo_bytepack_if #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .DEPTH_BYTES(DEPTH)) bus ();

    fifo_bytepack #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .DEPTH_BYTES(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] exp_q[$];
    int         m_level     = 0;
    bit         m_pending   = 1'b0;
    int         wbytes_cyc  = 0;
    int         n_vec       = 0;
    int         n_miss      = 0;
    longint     total_written = 0;
    int         n_concurrent  = 0;

    function automatic bit model_ready();
        return !reset && !m_pending && (m_level <= DEPTH - IN_BYTES);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; accepted bytes go to the scoreboard.
    task automatic drive(input bit v, input int sz, input logic [63:0] d,
                         input bit fl, input bit ro, input bit rs);
        @(posedge clock);
        #2;
        reset         = rs;
        bus.valid_in  = v;
        bus.size      = sz[2:0];
        bus.data_in   = d;
        bus.flush     = fl;
        bus.ready_out = ro;
        wbytes_cyc    = 0;
        if (v && model_ready()) begin
            for (int i = 0; i <= sz; i++) exp_q.push_back(d[8*i +: 8]);
            wbytes_cyc    = sz + 1;
            total_written += sz + 1;
        end
    endtask

    task automatic idle(input bit ro);
        drive(1'b0, 0, 64'h0, 1'b0, ro, 1'b0);
    endtask

    // Monitor: compares just before each rising edge, then advances the model across it.
    initial begin : monitor
        int         eb;
        int         rb;
        int         nl;
        bit         ev;
        bit         er;
        logic [31:0] ed;
        forever begin
            @(posedge clock);
            #8;
            ev = !reset && (m_level >= OUT_BYTES || (m_pending && m_level > 0));
            er = model_ready();
            eb = ev ? ((m_level >= OUT_BYTES) ? OUT_BYTES : m_level) : 0;
            ed = '0;
            for (int j = 0; j < eb; j++) ed[8*j +: 8] = exp_q[j];
            check("level",     64'(bus.level),     64'(m_level));
            check("valid_out", 64'(bus.valid_out), 64'(ev));
            check("ready_in",  64'(bus.ready_in),  64'(er));
            check("bytes_out", 64'(bus.bytes_out), 64'(eb));
            check("data_out",  64'(bus.data_out),  64'(ed));
            rb = (ev && bus.ready_out) ? eb : 0;
            if (rb > 0 && wbytes_cyc > 0) n_concurrent++;
            repeat (rb) void'(exp_q.pop_front());
            if (reset) begin
                exp_q.delete();
                m_level   = 0;
                m_pending = 1'b0;
            end else begin
                nl        = m_level + wbytes_cyc - rb;
                m_pending = (m_pending || (bus.flush && m_level > 0)) && (nl != 0);
                m_level   = nl;
            end
        end
    end

    initial begin : stimulus
        longint rand_start;
        bus.valid_in  = 1'b0;
        bus.size      = '0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.ready_out = 1'b0;

        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        #5;
        check("post_reset_ready", 64'(bus.ready_in), 64'd1);
        check("post_reset_valid", 64'(bus.valid_out), 64'd0);

        // Full beat
        drive(1'b1, 7, 64'h0807060504030201, 1'b0, 1'b1, 1'b0);
        idle(1'b1); #5;
        check("beat_word0", 64'(bus.data_out), 64'h04030201);
        check("beat_bytes0", 64'(bus.bytes_out), 64'd4);
        idle(1'b1); #5;
        check("beat_word1", 64'(bus.data_out), 64'h08070605);
        idle(1'b1); #5;
        check("beat_empty_valid", 64'(bus.valid_out), 64'd0);
        check("beat_empty_level", 64'(bus.level), 64'd0);

        // Packing of three 3-byte groups
        drive(1'b1, 2, 64'h030201, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 64'h060504, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2, 64'h090807, 1'b0, 1'b0, 1'b0);
        idle(1'b1); #5;
        check("pack_word0", 64'(bus.data_out), 64'h04030201);
        idle(1'b1); #5;
        check("pack_word1", 64'(bus.data_out), 64'h08070605);
        idle(1'b0); #5;
        check("pack_tail_valid", 64'(bus.valid_out), 64'd0);
        check("pack_tail_level", 64'(bus.level), 64'd1);

        // Flush of the trailing byte
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b0); #5;
        check("flush_valid", 64'(bus.valid_out), 64'd1);
        check("flush_data",  64'(bus.data_out),  64'h00000009);
        check("flush_bytes", 64'(bus.bytes_out), 64'd1);
        check("flush_ready_in", 64'(bus.ready_in), 64'd0);
        idle(1'b1);
        idle(1'b0); #5;
        check("flush_done_level", 64'(bus.level), 64'd0);
        check("flush_done_ready", 64'(bus.ready_in), 64'd1);

        // Full boundary
        for (int k = 0; k < 32; k++)
            drive(1'b1, 7, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        idle(1'b0); #5;
        check("full_level", 64'(bus.level), 64'd256);
        check("full_ready", 64'(bus.ready_in), 64'd0);
        idle(1'b1);
        idle(1'b0); #5;
        check("full_rd1_level", 64'(bus.level), 64'd252);
        check("full_rd1_ready", 64'(bus.ready_in), 64'd0);
        idle(1'b1);
        idle(1'b0); #5;
        check("full_rd2_level", 64'(bus.level), 64'd248);
        check("full_rd2_ready", 64'(bus.ready_in), 64'd1);

        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic with wraps, flushes and concurrent accepts
        rand_start   = total_written;
        n_concurrent = 0;
        for (int k = 0; k < 2000; k++)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), {$urandom, $urandom},
                  $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6, 1'b0);
        check("wrap_cover", 64'(total_written - rand_start >= 10 * DEPTH), 64'd1);
        check("concurrent_cover", 64'(n_concurrent > 0), 64'd1);

        // Reset with data stored and a flush pending
        drive(1'b0, 0, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++)
            drive(1'b1, 7, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 64'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b0); #5;
        check("rst_pre_level", 64'(bus.level), 64'd100);
        check("rst_pre_ready", 64'(bus.ready_in), 64'd0);
        drive(1'b0, 0, 64'h0, 1'b0, 1'b1, 1'b1); #5;
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_ready", 64'(bus.ready_in), 64'd0);
        check("rst_data",  64'(bus.data_out), 64'd0);
        idle(1'b1); #5;
        check("rst_post_level", 64'(bus.level), 64'd0);
        check("rst_post_valid", 64'(bus.valid_out), 64'd0);
        check("rst_post_ready", 64'(bus.ready_in), 64'd1);
        idle(1'b1);
        idle(1'b1); #5;
        check("rst_no_stale", 64'(bus.valid_out), 64'd0);

        @(posedge clock);
        #9;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fifo_bytepack.md
# fifo_bytepack

Parametrised byte-granular, width-converting FIFO: the next generation of the lab FIFO. Producers push variable-length byte groups (1..IN_BYTES valid bytes per beat). The block repacks them into fixed OUT_BYTES words with full valid/ready handshakes on both sides. An explicit flush drains a trailing partial word with a byte count. It sits between a wide variable-size source and a narrower fixed-width consumer that can apply backpressure.

## Interface
- IN_BYTES, 8: input beat width in bytes; power of 2, ≥ OUT_BYTES.
- OUT_BYTES, 4: output word width in bytes; power of 2.
- DEPTH_BYTES, 256: storage in bytes; power of 2, multiple of IN_BYTES, ≥ 2*IN_BYTES.
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  input beat valid.
- ready_in  output  1  block can accept a beat.
- size  input  clog2(IN_BYTES)  valid byte count minus 1; bytes packed from data_in LSB.
- data_in  input  8*IN_BYTES  input bytes; byte 0 = [7:0], enqueued first.
- flush  input  1  one-cycle request to drain a trailing partial word.
- valid_out  output  1  data_out holds a word.
- ready_out  input  1  consumer accepts the word.
- data_out  output  8*OUT_BYTES  output bytes; oldest byte in [7:0].
- bytes_out  output  clog2(OUT_BYTES)+1  valid bytes in data_out (1..OUT_BYTES).
- level  output  clog2(DEPTH_BYTES)+1  bytes currently stored.

## Operation
- Storage: circular byte array, write pointer wr_ptr, read pointer rd_ptr, each clog2(DEPTH_BYTES) bits, wrapping modulo DEPTH_BYTES. level is a register, 0..DEPTH_BYTES.
- Write accept: valid_in && ready_in. It stores bytes 0..size at wr_ptr..wr_ptr+size (mod depth), then wr_ptr += size+1.
- ready_in = (DEPTH_BYTES − level ≥ IN_BYTES) && !flush_pending && !reset. This is conservative: it is independent of size, so overflow is impossible.
- Read side is show-ahead. data_out presents bytes rd_ptr..rd_ptr+bytes_out−1 combinationally from storage. Bytes above bytes_out read as 0.
- valid_out = !reset && (level ≥ OUT_BYTES || (flush_pending && level > 0)).
- bytes_out = OUT_BYTES if level ≥ OUT_BYTES, else level. data_out = 0 and bytes_out = 0 when valid_out = 0.
- Read accept: valid_out && ready_out. It sets rd_ptr += bytes_out.
- Simultaneous accept: level_next = level + wbytes − rbytes, with each term 0 if that side is not accepted. Reads use pre-write level and data; same-cycle written bytes are not readable.
- Flush state, flush_pending (1 bit):
  - IDLE → DRAIN when flush=1 && level > 0. flush with level = 0 is a no-op.
  - DRAIN → IDLE in the cycle the read accept makes level_next = 0.
  - flush asserted during DRAIN is ignored.
  - While in DRAIN, ready_in = 0, so no new bytes join the drain.
- Without flush, fewer than OUT_BYTES bytes stay stored indefinitely.

## Timing
- Reset (synchronous, in the cycle reset is sampled high): wr_ptr = rd_ptr = 0, level = 0, flush_pending = 0. While reset is high, valid_out = 0, ready_in = 0, data_out = 0, bytes_out = 0. Storage contents are not reset.
- First cycle after reset deasserts: ready_in = 1, valid_out = 0, level = 0.
- Reset mid-operation discards all stored data and any pending flush. There is no partial output afterwards.
- Write-to-read latency is 1 cycle. A write accepted in cycle N that raises level to ≥ OUT_BYTES gives valid_out = 1 in cycle N+1.
- Throughput: one input beat and one output word per cycle, with no bubbles at steady state.
- ready_in and valid_out depend only on registered state and reset. There is no combinational path from valid_in or ready_out to either.
- Full boundary: ready_in drops when level > DEPTH_BYTES − IN_BYTES. It recovers in the cycle after the read accept that brings level ≤ DEPTH_BYTES − IN_BYTES.
- Empty boundary: level < OUT_BYTES and no flush pending gives valid_out = 0.
- Pointer wrap: a byte group or output word that straddles DEPTH_BYTES−1 → 0 must be stored and read contiguously in byte order.

## Test plan
Defaults: IN_BYTES = 8, OUT_BYTES = 4, DEPTH_BYTES = 256.
- Full beat: after reset, write data_in = 64'h0807060504030201, size = 7, with ready_out = 1.
  - Next cycle: data_out = 32'h04030201, bytes_out = 4.
  - Then: data_out = 32'h08070605.
  - Then: valid_out = 0, level = 0.
- Packing: three writes of size = 2 with data_in low bytes 0x030201, 0x060504, 0x090807, and ready_out = 0.
  - Then ready_out = 1: outputs 32'h04030201, then 32'h08070605.
  - Finally: valid_out = 0, level = 1.
- Flush: from the previous end state (level = 1, byte 0x09), pulse flush for 1 cycle.
  - Next cycle: valid_out = 1, data_out = 32'h00000009, bytes_out = 1, ready_in = 0.
  - After accept: level = 0, ready_in = 1 the following cycle.
- Full: with ready_out = 0, write 8 bytes every cycle.
  - After 32 accepts: level = 256, ready_in = 0.
  - One read gives level = 252 with ready_in still 0.
  - Second read gives level = 248 and ready_in = 1 next cycle.
- Wrap and concurrency: 2000 cycles of random valid_in, size, ready_out and flush. Compare against a byte-queue model.
  - Byte order, bytes_out and level must match every cycle, across ≥ 10 pointer wraps.
  - Include simultaneous read and write accepts.
- Reset mid-operation: with level = 100 and flush_pending = 1, assert reset for 1 cycle.
  - While reset is high: valid_out = ready_in = 0.
  - Next cycle: level = 0, valid_out = 0, ready_in = 1. Stale data never appears.
